// File: rtl/if_buf.sv
// Instruction fetch buffer: an in-order circular FIFO of fetch packets between
// fetch and decode. A faulting fetch blocks further pushes until a redirect flush.
module if_buf #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [PC_WIDTH-1:0]        in_pc_i,
    input  logic [INSTR_WIDTH-1:0]     in_instr_i,
    input  logic                       in_pc_misalign_i,
    input  logic                       in_bus_err_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [PC_WIDTH-1:0]        out_pc_o,
    output logic [INSTR_WIDTH-1:0]     out_instr_o,
    output logic                       out_pc_misalign_o,
    output logic                       out_bus_err_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
        logic                   misalign;
        logic                   bus_err;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               fault_hold;

    logic               push;
    logic               pop;
    logic               in_fault;

    always_comb begin
        in_ready_o  = (count != FULL_CNT) && !fault_hold;
        out_valid_o = (count != '0);
        push        = in_valid_i && in_ready_o && !flush_i;
        pop         = out_valid_o && out_ready_i && !flush_i;
        in_fault    = in_pc_misalign_i || in_bus_err_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem        <= '{default: '0};
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fault_hold <= 1'b0;
        end else if (flush_i) begin
            // Entry contents are left stale; the zeroed count hides them.
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fault_hold <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{pc: in_pc_i, instr: in_instr_i,
                                 misalign: in_pc_misalign_i, bus_err: in_bus_err_i};
                wr_ptr      <= wr_ptr + PTR_W'(1);
                if (in_fault) begin
                    fault_hold <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        out_pc_o          = mem[rd_ptr].pc;
        out_instr_o       = mem[rd_ptr].instr;
        out_pc_misalign_o = mem[rd_ptr].misalign;
        out_bus_err_o     = mem[rd_ptr].bus_err;
        count_o           = count;
    end

endmodule

// File: tb/tb_if_buf.sv
// Bench for if_buf: a queue-based model checked every cycle, plus directed
// vectors with literal expectations.
module tb_if_buf;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_pc_i = '0;
    logic [31:0] in_instr_i = '0;
    logic        in_pc_misalign_i = 1'b0;
    logic        in_bus_err_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_pc_o;
    logic [31:0] out_instr_o;
    logic        out_pc_misalign_o;
    logic        out_bus_err_o;
    logic [2:0]  count_o;

    if_buf #(.PC_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_pc_i(in_pc_i), .in_instr_i(in_instr_i),
        .in_pc_misalign_i(in_pc_misalign_i), .in_bus_err_i(in_bus_err_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .out_instr_o(out_instr_o),
        .out_pc_misalign_o(out_pc_misalign_o), .out_bus_err_o(out_bus_err_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a queue of packets plus the fault block flag.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
        logic        be;
    } pkt_t;

    pkt_t m_q[$];
    bit   m_hold = 1'b0;

    function automatic bit m_ready();
        return (m_q.size() != DEPTH) && !m_hold;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_hold = 1'b0;
        end else if (flush_i) begin
            m_q.delete();
            m_hold = 1'b0;
        end else begin
            bit   do_push;
            bit   do_pop;
            pkt_t p;
            do_push = in_valid_i && m_ready();
            do_pop  = (m_q.size() != 0) && out_ready_i;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                p.pc = in_pc_i; p.instr = in_instr_i;
                p.mis = in_pc_misalign_i; p.be = in_bus_err_i;
                m_q.push_back(p);
                if (in_pc_misalign_i || in_bus_err_i) m_hold = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("mdl_in_ready", 64'(in_ready_o), 64'(m_ready()));
        chk("mdl_out_valid", 64'(out_valid_o), 64'(m_q.size() != 0));
        chk("mdl_count", 64'(count_o), 64'(m_q.size()));
        if (m_q.size() != 0) begin
            chk("mdl_pc", 64'(out_pc_o), 64'(m_q[0].pc));
            chk("mdl_instr", 64'(out_instr_o), 64'(m_q[0].instr));
            chk("mdl_mis", 64'(out_pc_misalign_o), 64'(m_q[0].mis));
            chk("mdl_be", 64'(out_bus_err_o), 64'(m_q[0].be));
        end
    end

    // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic drive(input logic v, input logic [31:0] pc, input logic mis,
                         input logic be, input logic rdy, input logic fl);
        in_valid_i = v;
        in_pc_i = pc;
        in_instr_i = {16'hC0DE, pc[15:0]};
        in_pc_misalign_i = mis;
        in_bus_err_i = be;
        out_ready_i = rdy;
        flush_i = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 32'h0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        logic [31:0] exp_pc [4];

        // Reset values while rst_n is held low
        #2;
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_out_pc", 64'(out_pc_o), 64'd0);
        chk("rst_out_instr", 64'(out_instr_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Queue three, then drain in order
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("q3_count", 64'(count_o), 64'd3);
        chk("q3_in_ready", 64'(in_ready_o), 64'd1);
        chk("q3_head_pc", 64'(out_pc_o), 64'h0);
        chk("q3_head_instr", 64'(out_instr_o), 64'hC0DE_0000);
        idle(1'b1);
        chk("drain_pc1", 64'(out_pc_o), 64'h4);
        idle(1'b1);
        chk("drain_pc2", 64'(out_pc_o), 64'h8);
        idle(1'b1);
        chk("drain_empty", 64'(out_valid_o), 64'd0);

        // Fill, reject a fifth, pop one, refill across the wrap
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_count", 64'(count_o), 64'd4);
        chk("full_in_ready", 64'(in_ready_o), 64'd0);
        drive(1'b1, 32'h110, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_reject", 64'(count_o), 64'd4);
        idle(1'b1);
        chk("after_pop_ready", 64'(in_ready_o), 64'd1);
        chk("after_pop_count", 64'(count_o), 64'd3);
        drive(1'b1, 32'h114, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_pc[0] = 32'h108; exp_pc[1] = 32'h10C; exp_pc[2] = 32'h114;
        chk("wrap_head0", 64'(out_pc_o), 64'h104);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            chk("wrap_order", 64'(out_pc_o), 64'(exp_pc[i]));
        end
        idle(1'b1);
        chk("wrap_empty", 64'(out_valid_o), 64'd0);

        // Streaming: one in, one out each cycle
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h200 + 32'(4 * k), 1'b0, 1'b0, 1'b1, 1'b0);
            chk("stream_count", 64'(count_o), 64'd1);
            chk("stream_pc", 64'(out_pc_o), 64'h200 + 64'(4 * k));
        end
        idle(1'b1);
        chk("stream_empty", 64'(count_o), 64'd0);

        // Bus-error fetch blocks pushes until flush
        drive(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("fault_ready_low", 64'(in_ready_o), 64'd0);
        chk("fault_be_out", 64'(out_bus_err_o), 64'd1);
        drive(1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("fault_drained", 64'(count_o), 64'd0);
        chk("fault_still_held", 64'(in_ready_o), 64'd0);
        idle(1'b0);
        chk("fault_held_idle", 64'(in_ready_o), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("flush_ready", 64'(in_ready_o), 64'd1);
        chk("flush_count", 64'(count_o), 64'd0);

        // Faulting push together with a pop
        drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h44, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("fpop_count", 64'(count_o), 64'd1);
        chk("fpop_ready", 64'(in_ready_o), 64'd0);
        chk("fpop_pc", 64'(out_pc_o), 64'h44);
        chk("fpop_mis", 64'(out_pc_misalign_o), 64'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Flush beats a concurrent push
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h30 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_flush_count", 64'(count_o), 64'd3);
        drive(1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("flushpush_count", 64'(count_o), 64'd0);
        chk("flushpush_valid", 64'(out_valid_o), 64'd0);
        idle(1'b1);
        idle(1'b1);
        chk("flushpush_gone", 64'(out_valid_o), 64'd0);

        // Asynchronous reset mid-stream
        drive(1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h54, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_count", 64'(count_o), 64'd2);
        in_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid_o), 64'd0);
        chk("arst_count", 64'(count_o), 64'd0);
        chk("arst_ready", 64'(in_ready_o), 64'd1);
        chk("arst_pc", 64'(out_pc_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1'b0);
        chk("post_rst_count", 64'(count_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_buf.md
# if_buf

Instruction fetch buffer between the fetch stage and decode. It accepts fetched instruction packets: PC, instruction word, and the fetch exception flags (PC misalign, bus error). It queues them in order in a small circular FIFO and presents them to decode over a valid/ready handshake. A flush from a branch/jump redirect discards all queued packets, and a faulting fetch blocks further fetches until that flush arrives.

## Interface
- PC_WIDTH, 32, PC width in bits
- INSTR_WIDTH, 32, instruction word width in bits
- DEPTH, 4, number of entries; power of two, ≥2
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush_i  input  1  redirect; discards all entries and clears the fault block
- in_valid_i  input  1  fetch packet valid
- in_ready_o  output  1  buffer can accept a packet
- in_pc_i  input  PC_WIDTH  PC of the fetched instruction
- in_instr_i  input  INSTR_WIDTH  fetched instruction
- in_pc_misalign_i  input  1  fetch PC misaligned
- in_bus_err_i  input  1  fetch bus error
- out_valid_o  output  1  head entry valid
- out_ready_i  input  1  decode accepts head entry
- out_pc_o  output  PC_WIDTH  head PC
- out_instr_o  output  INSTR_WIDTH  head instruction
- out_pc_misalign_o  output  1  head misalign flag
- out_bus_err_o  output  1  head bus error flag
- count_o  output  $clog2(DEPTH)+1  number of occupied entries

## Operation
- Storage: DEPTH entries of {pc, instr, misalign, bus_err}, a write pointer, a read pointer (each $clog2(DEPTH) bits, wrapping modulo DEPTH), a count, and a fault_hold flag.
- Push: occurs when in_valid_i & in_ready_o & !flush_i. The packet is written at the write pointer, and the write pointer advances.
- Pop: occurs when out_valid_o & out_ready_i & !flush_i. The read pointer advances.
- Count: +1 on push only, −1 on pop only, unchanged when both happen in the same cycle.
- in_ready_o = (count != DEPTH) & !fault_hold. It is not a function of out_ready_i; there is no full-pass-through.
- out_valid_o = (count != 0). The head data outputs are driven from the entry at the read pointer. There is no empty bypass: an input is never forwarded combinationally to the output.
- Fault hold: a push with in_pc_misalign_i | in_bus_err_i sets fault_hold on that edge, and in_ready_o drops the next cycle. Already-queued entries and the faulting entry still drain normally. fault_hold clears only on flush_i.
- Flush: flush_i high at an edge sets count, both pointers, and fault_hold to 0. Any push or pop offered in that cycle is ignored; decode must not treat a head presented during a flush cycle as consumed. Entry contents need not be cleared.
- States, implied by count and fault_hold:
  - EMPTY (count 0)
  - PARTIAL
  - FULL (count DEPTH)
  - each of the above with HOLD. HOLD is left only via flush.
- Reset (rst_n low, asynchronous): pointers 0, count 0, fault_hold 0, all entries 0.
  - Outputs during reset: in_ready_o 1, out_valid_o 0, out_pc_o 0, out_instr_o 0, both flags 0, count_o 0.
  - Reset asserted mid-stream discards everything immediately, with no edge required.

## Timing
- Latency: a packet pushed at edge N appears on the outputs with out_valid_o high after edge N, i.e. in cycle N+1. The minimum input-to-output latency is 1 cycle.
- Throughput is one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- In FULL, in_ready_o is low. A pop at edge N makes in_ready_o high in cycle N+1.
- All outputs are functions of registered state only: no combinational path from any input to any output.
- Simultaneous flush and push: the flush wins; the count after the edge is 0.
- Simultaneous faulting push and pop: the faulting entry is stored, fault_hold sets, and the pop is applied.

## Test plan
- Reset, then push PCs 0x0, 0x4, 0x8 with out_ready_i=0 -> count_o=3, in_ready_o=1, head out_pc_o=0x0. Then hold out_ready_i=1 -> pops in order 0x0, 0x4, 0x8, then out_valid_o=0.
- Fill: push 4 packets with out_ready_i=0 -> count_o=4, in_ready_o=0, and a 5th offered packet is not stored. Pop one -> in_ready_o=1 the next cycle. Continue the push stream past the wrap point -> order is preserved across the pointer wrap.
- Streaming: in_valid_i=1 and out_ready_i=1 continuously -> count_o stays 1 after the first edge, and one packet pops per cycle with the 1-cycle latency.
- Fault: push 0x10 with in_bus_err_i=1 -> in_ready_o=0 from the next cycle. The entry drains with out_bus_err_o=1, and in_ready_o stays 0 until a flush_i pulse; after the flush, in_ready_o=1 and count_o=0.
- Flush with a concurrent push of 0x20 while count_o=3 -> count_o=0 after the edge, out_valid_o=0, and 0x20 is never output.
- Assert rst_n low asynchronously with count_o=2 -> out_valid_o=0 and count_o=0 immediately, before the next clock edge.
